// File: rtl/dco_idc.sv
// Digitally controlled oscillator with a K-counter loop filter that trims the output period.
// Optional lock detector is enabled with `define DCO_IDC_LOCK_DETECT_EN.
module dco_idc #(
    parameter int CNT_W    = 8,
    parameter int P_NOM    = 20,
    parameter int P_MIN    = 8,
    parameter int P_MAX    = 200,
    parameter int K        = 4,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lead,
    input  logic             lag,
    input  logic             ref_rise,
    output logic             ctrl_signal,
    output logic [CNT_W-1:0] period,
    output logic             carry,
    output logic             borrow
`ifdef DCO_IDC_LOCK_DETECT_EN
    ,
    output logic             locked
`endif
);

    // kcnt spans -K..+K, so one extra bit beyond the magnitude for the sign
    localparam int KW = $clog2(K + 1) + 1;
    localparam logic signed [KW-1:0] K_POS = KW'(K);
    localparam logic signed [KW-1:0] K_NEG = KW'(-K);
    localparam logic signed [KW-1:0] K_ONE = KW'(1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] NOM_N   = CNT_W'(P_NOM);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(P_MIN);
    localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(P_MAX);
    localparam logic [CNT_W:0]   MIN_X   = (CNT_W + 1)'(P_MIN);
    localparam logic [CNT_W:0]   MAX_X   = (CNT_W + 1)'(P_MAX);
    localparam logic [CNT_W:0]   STEP_X  = (CNT_W + 1)'(STEP);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_tgt_q, period_tgt_d;
    logic [CNT_W-1:0]     period_act_q, period_act_d;
    logic signed [KW-1:0] kcnt_q, kcnt_d, kcnt_up, kcnt_dn;
    logic                 ctrl_q, ctrl_d;
    logic                 carry_q, carry_d;
    logic                 borrow_q, borrow_d;
    logic                 wrap, vote_up, vote_dn;
    logic [CNT_W:0]       tgt_x, dec_x, inc_x;

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        wrap         = (cnt_q == period_act_q - ONE);
        cnt_d        = wrap ? '0 : cnt_q + ONE;
        ctrl_d       = (cnt_q < (period_act_q >> 1));
        // Period only changes at the wrap so the current half-period is never cut short
        period_act_d = wrap ? period_tgt_q : period_act_q;

        vote_up      = ref_rise & lag & ~lead;
        vote_dn      = ref_rise & lead & ~lag;
        kcnt_up      = kcnt_q + K_ONE;
        kcnt_dn      = kcnt_q - K_ONE;
        tgt_x        = {1'b0, period_tgt_q};
        dec_x        = tgt_x - STEP_X;
        inc_x        = tgt_x + STEP_X;

        kcnt_d       = kcnt_q;
        period_tgt_d = period_tgt_q;
        carry_d      = 1'b0;
        borrow_d     = 1'b0;

        if (vote_up) begin
            if (kcnt_up == K_POS) begin
                kcnt_d       = '0;
                carry_d      = 1'b1;
                period_tgt_d = (tgt_x < MIN_X + STEP_X) ? MIN_N : dec_x[CNT_W-1:0];
            end else begin
                kcnt_d = kcnt_up;
            end
        end else if (vote_dn) begin
            if (kcnt_dn == K_NEG) begin
                kcnt_d       = '0;
                borrow_d     = 1'b1;
                period_tgt_d = (inc_x > MAX_X) ? MAX_N : inc_x[CNT_W-1:0];
            end else begin
                kcnt_d = kcnt_dn;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            period_tgt_q <= NOM_N;
            period_act_q <= NOM_N;
            kcnt_q       <= '0;
            ctrl_q       <= 1'b0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_tgt_q <= period_tgt_d;
            period_act_q <= period_act_d;
            kcnt_q       <= kcnt_d;
            ctrl_q       <= ctrl_d;
            carry_q      <= carry_d;
            borrow_q     <= borrow_d;
        end
    end

    assign ctrl_signal = ctrl_q;
    assign period      = period_act_q;
    assign carry       = carry_q;
    assign borrow      = borrow_q;

`ifdef DCO_IDC_LOCK_DETECT_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LOCK_N = LW'(LOCK_CNT);

    logic [LW-1:0] lock_q, lock_d;

    // Any phase error or period step restarts the in-phase run
    always_comb begin
        lock_d = lock_q;
        if ((ref_rise & (lead | lag)) | carry_q | borrow_q) begin
            lock_d = '0;
        end else if (ref_rise && lock_q != LOCK_N) begin
            lock_d = lock_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = (lock_q == LOCK_N);
`endif

endmodule

// File: tb/tb_dco_idc.sv
// Directed self-checking bench for dco_idc: default instance plus two saturation instances.
module tb_dco_idc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lead = 1'b0, lag = 1'b0, ref_rise = 1'b0;
    logic       lo_lag = 1'b0, lo_rise = 1'b0;
    logic       hi_lead = 1'b0, hi_rise = 1'b0;
    logic       ctrl_signal, carry, borrow;
    logic [7:0] period;
    logic       lo_ctrl, lo_carry, lo_borrow;
    logic [7:0] lo_period;
    logic       hi_ctrl, hi_carry, hi_borrow;
    logic [7:0] hi_period;
`ifdef DCO_IDC_LOCK_DETECT_EN
    logic       locked, lo_locked, hi_locked;
`endif

    int checks = 0;
    int errors = 0;
    int n_carry = 0, n_borrow = 0, n_lo_carry = 0, n_hi_borrow = 0;

    dco_idc dut (
        .clk(clk), .rst_n(rst_n), .lead(lead), .lag(lag), .ref_rise(ref_rise),
        .ctrl_signal(ctrl_signal), .period(period), .carry(carry), .borrow(borrow)
`ifdef DCO_IDC_LOCK_DETECT_EN
        , .locked(locked)
`endif
    );

    dco_idc #(.P_NOM(8)) dut_lo (
        .clk(clk), .rst_n(rst_n), .lead(1'b0), .lag(lo_lag), .ref_rise(lo_rise),
        .ctrl_signal(lo_ctrl), .period(lo_period), .carry(lo_carry), .borrow(lo_borrow)
`ifdef DCO_IDC_LOCK_DETECT_EN
        , .locked(lo_locked)
`endif
    );

    dco_idc #(.P_NOM(199), .STEP(2)) dut_hi (
        .clk(clk), .rst_n(rst_n), .lead(hi_lead), .lag(1'b0), .ref_rise(hi_rise),
        .ctrl_signal(hi_ctrl), .period(hi_period), .carry(hi_carry), .borrow(hi_borrow)
`ifdef DCO_IDC_LOCK_DETECT_EN
        , .locked(hi_locked)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (carry === 1'b1)     n_carry++;
        if (borrow === 1'b1)    n_borrow++;
        if (lo_carry === 1'b1)  n_lo_carry++;
        if (hi_borrow === 1'b1) n_hi_borrow++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vote(input logic ld, input logic lg, input logic rr);
        lead = ld; lag = lg; ref_rise = rr;
        @(negedge clk);
        lead = 1'b0; lag = 1'b0; ref_rise = 1'b0;
    endtask

    task automatic sync_rise(output bit ok);
        int b = 0;
        while (ctrl_signal !== 1'b0 && b < 1000) begin @(negedge clk); b++; end
        while (ctrl_signal !== 1'b1 && b < 1000) begin @(negedge clk); b++; end
        ok = (b < 1000);
    endtask

    task automatic measure(output int hi, output int lo);
        bit ok;
        sync_rise(ok);
        hi = 0;
        lo = 0;
        if (!ok) begin
            hi = -1;
            lo = -1;
        end else begin
            while (ctrl_signal === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
            while (ctrl_signal === 1'b0 && lo < 1000) begin lo++; @(negedge clk); end
        end
    endtask

    initial begin
        int hi, lo, c0, b0;
        bit ok;

        // Reset state
        step(2);
        check("rst_period", 32'(period), 32'd20);
        check("rst_ctrl", 32'(ctrl_signal), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_lo_period", 32'(lo_period), 32'd8);
        check("rst_hi_period", 32'(hi_period), 32'd199);

        // Free run at the nominal period
        rst_n = 1'b1;
        @(negedge clk);
        check("first_rise", 32'(ctrl_signal), 32'd1);
        c0 = n_carry; b0 = n_borrow;
        step(200);
        check("idle_carry", 32'(n_carry - c0), 32'd0);
        check("idle_borrow", 32'(n_borrow - b0), 32'd0);
        check("idle_period", 32'(period), 32'd20);
        measure(hi, lo);
        check("nom_high", 32'(hi), 32'd10);
        check("nom_low", 32'(lo), 32'd10);

        // Four lag votes: one carry, period 19 from the next wrap
        sync_rise(ok);
        check("sync1", 32'(ok), 32'd1);
        c0 = n_carry;
        repeat (3) vote(1'b0, 1'b1, 1'b1);
        check("carry_before_k", 32'(carry), 32'd0);
        vote(1'b0, 1'b1, 1'b1);
        check("carry_pulse", 32'(carry), 32'd1);
        check("period_hold", 32'(period), 32'd20);
        step(1);
        check("carry_one_cycle", 32'(carry), 32'd0);
        measure(hi, lo);
        check("p19_high", 32'(hi), 32'd9);
        check("p19_low", 32'(lo), 32'd10);
        check("p19_period", 32'(period), 32'd19);
        check("carry_count", 32'(n_carry - c0), 32'd1);

        // Four lead votes: one borrow, back to 20
        sync_rise(ok);
        b0 = n_borrow;
        repeat (3) vote(1'b1, 1'b0, 1'b1);
        check("borrow_before_k", 32'(borrow), 32'd0);
        vote(1'b1, 1'b0, 1'b1);
        check("borrow_pulse", 32'(borrow), 32'd1);
        measure(hi, lo);
        check("p20_high", 32'(hi), 32'd10);
        check("p20_low", 32'(lo), 32'd10);
        check("p20_period", 32'(period), 32'd20);
        check("borrow_count", 32'(n_borrow - b0), 32'd1);

        // Alternating votes, illegal and unqualified inputs: no steps
        c0 = n_carry; b0 = n_borrow;
        for (int i = 0; i < 20; i++) begin
            vote(1'b0, 1'b1, 1'b1);
            vote(1'b1, 1'b0, 1'b1);
        end
        repeat (4) vote(1'b1, 1'b1, 1'b1);
        repeat (5) vote(1'b0, 1'b1, 1'b0);
        repeat (5) vote(1'b1, 1'b0, 1'b0);
        step(2);
        check("alt_carry", 32'(n_carry - c0), 32'd0);
        check("alt_borrow", 32'(n_borrow - b0), 32'd0);
        check("alt_period", 32'(period), 32'd20);
        // kcnt must still be 0: three lags are not enough, the fourth is
        repeat (3) vote(1'b0, 1'b1, 1'b1);
        step(2);
        check("kcnt_kept_3", 32'(n_carry - c0), 32'd0);
        vote(1'b0, 1'b1, 1'b1);
        step(2);
        check("kcnt_kept_4", 32'(n_carry - c0), 32'd1);

        // Two more steps down to 17, then reset mid-high-phase
        repeat (8) vote(1'b0, 1'b1, 1'b1);
        measure(hi, lo);
        check("p17_high", 32'(hi), 32'd8);
        check("p17_low", 32'(lo), 32'd9);
        check("p17_period", 32'(period), 32'd17);
        repeat (2) vote(1'b0, 1'b1, 1'b1);
        sync_rise(ok);
        step(2);
        check("pre_rst_ctrl", 32'(ctrl_signal), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ctrl", 32'(ctrl_signal), 32'd0);
        check("async_period", 32'(period), 32'd20);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = n_carry;
        repeat (3) vote(1'b0, 1'b1, 1'b1);
        step(2);
        check("kcnt_cleared", 32'(n_carry - c0), 32'd0);
        measure(hi, lo);
        check("post_rst_high", 32'(hi), 32'd10);
        check("post_rst_low", 32'(lo), 32'd10);

        // Saturation at P_MIN: carries still pulse, period stays 8
        c0 = n_lo_carry;
        for (int i = 0; i < 8; i++) begin
            lo_lag = 1'b1; lo_rise = 1'b1;
            @(negedge clk);
            lo_lag = 1'b0; lo_rise = 1'b0;
        end
        step(40);
        check("lo_carries", 32'(n_lo_carry - c0), 32'd2);
        check("lo_period", 32'(lo_period), 32'd8);

        // Saturation at P_MAX: 199 + 2 clamps to 200
        b0 = n_hi_borrow;
        for (int i = 0; i < 4; i++) begin
            hi_lead = 1'b1; hi_rise = 1'b1;
            @(negedge clk);
            hi_lead = 1'b0; hi_rise = 1'b0;
        end
        step(2);
        check("hi_borrows", 32'(n_hi_borrow - b0), 32'd1);
        step(450);
        check("hi_period", 32'(hi_period), 32'd200);

`ifdef DCO_IDC_LOCK_DETECT_EN
        check("lock_start", 32'(locked), 32'd0);
        repeat (7) vote(1'b0, 1'b0, 1'b1);
        check("lock_after_7", 32'(locked), 32'd0);
        vote(1'b0, 1'b0, 1'b1);
        check("lock_after_8", 32'(locked), 32'd1);
        step(3);
        check("lock_held", 32'(locked), 32'd1);
        vote(1'b0, 1'b1, 1'b1);
        check("lock_cleared", 32'(locked), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
